// File: rtl/uart_rx_capture_pkg.sv
// Shared types and constants for the UART RX capture stage.
package uart_rx_capture_pkg;

  localparam int unsigned ByteW = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StEcho = 2'd1,
    StWait = 2'd2
  } state_e;

endpackage

// File: rtl/uart_rx_capture_if.sv
// UART FIFO handshake bundle: RX pop side and TX push side.
interface uart_rx_capture_if;
  import uart_rx_capture_pkg::*;

  logic             rx_empty;
  logic [ByteW-1:0] r_data;
  logic             rd_uart;
  logic             tx_full;
  logic             wr_uart;
  logic [ByteW-1:0] w_data;

  // master: the capture stage; slave: the FIFO pair
  modport master (
    input  rx_empty,
    input  r_data,
    input  tx_full,
    output rd_uart,
    output wr_uart,
    output w_data
  );

  modport slave (
    output rx_empty,
    output r_data,
    output tx_full,
    input  rd_uart,
    input  wr_uart,
    input  w_data
  );

endinterface

// File: rtl/uart_rx_capture_disp_shift_reg.sv
// Byte-wide shift register feeding the hex display; newest byte lands in [7:0].
module uart_rx_capture_disp_shift_reg
  import uart_rx_capture_pkg::*;
#(
  parameter int unsigned DispW = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [ByteW-1:0] byte_i,
  output logic [DispW-1:0] disp_o
);

  logic [DispW-1:0] disp_d, disp_q;
  logic [DispW-1:0] shifted;

  if (DispW > ByteW) begin : g_shift
    assign shifted = {disp_q[DispW-ByteW-1:0], byte_i};
  end else begin : g_single
    assign shifted = byte_i;
  end

  always_comb begin
    disp_d = disp_q;
    if (load_i) begin
      disp_d = shifted;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_q <= '0;
    end else begin
      disp_q <= disp_d;
    end
  end

  assign disp_o = disp_q;

endmodule

// File: rtl/uart_rx_capture.sv
// Pops bytes from the UART RX FIFO into a display shift register and counts them.
// Optional TX echo of every byte is enabled by defining UART_RX_ECHO_EN.
module uart_rx_capture
  import uart_rx_capture_pkg::*;
#(
  parameter int unsigned DISP_W = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  uart_rx_capture_if.master   bus,
  output logic [DISP_W-1:0]   disp_val,
  output logic [CNT_W-1:0]    byte_cnt,
  output logic                new_byte
);

`ifdef UART_RX_ECHO_EN
  localparam state_e AfterPop = StEcho;
`else
  localparam state_e AfterPop = StWait;
`endif

  state_e           state_q, state_d;
  logic             armed_q;
  logic             take;
  logic             rd_d, rd_q;
  logic             nb_d, nb_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
`ifdef UART_RX_ECHO_EN
  logic [ByteW-1:0] byte_d, byte_q;
  logic [ByteW-1:0] wdata_d, wdata_q;
  logic             wr_d, wr_q;
`endif

  // armed_q keeps the first edge after reset release strobe-free
  assign take = (state_q == StIdle) && armed_q && !bus.rx_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (take) state_d = AfterPop;
`ifdef UART_RX_ECHO_EN
      StEcho: if (!bus.tx_full) state_d = StWait;
`endif
      StWait: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_d  = take;
    nb_d  = take;
    cnt_d = take ? cnt_q + CNT_W'(1) : cnt_q;
`ifdef UART_RX_ECHO_EN
    byte_d  = take ? bus.r_data : byte_q;
    wr_d    = (state_q == StEcho) && !bus.tx_full;
    wdata_d = wr_d ? byte_q : wdata_q;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q    <= 1'b0;
      nb_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef UART_RX_ECHO_EN
      byte_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
`endif
    end else begin
      rd_q    <= rd_d;
      nb_q    <= nb_d;
      cnt_q   <= cnt_d;
`ifdef UART_RX_ECHO_EN
      byte_q  <= byte_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
`endif
    end
  end

  uart_rx_capture_disp_shift_reg #(
    .DispW (DISP_W)
  ) u_disp (
    .clk    (clk),
    .reset  (reset),
    .load_i (take),
    .byte_i (bus.r_data),
    .disp_o (disp_val)
  );

  assign bus.rd_uart = rd_q;
  assign new_byte    = nb_q;
  assign byte_cnt    = cnt_q;

`ifdef UART_RX_ECHO_EN
  assign bus.wr_uart = wr_q;
  assign bus.w_data  = wdata_q;
`else
  logic unused_tx_full;
  assign unused_tx_full = bus.tx_full;
  assign bus.wr_uart    = 1'b0;
  assign bus.w_data     = '0;
`endif

endmodule

// File: tb/tb_uart_rx_capture.sv
// Randomised scoreboard bench for uart_rx_capture; honours UART_RX_ECHO_EN.
module tb_uart_rx_capture;
  import uart_rx_capture_pkg::*;

  localparam int unsigned DispW  = 16;
  localparam int unsigned CntW   = 8;
  localparam int          NBytes = DispW / 8;
`ifdef UART_RX_ECHO_EN
  localparam int PopGap = 3;
`else
  localparam int PopGap = 2;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DispW-1:0]  disp_val;
  logic [CntW-1:0]   byte_cnt;
  logic              new_byte;

  uart_rx_capture_if bus ();

  uart_rx_capture #(
    .DISP_W (DispW),
    .CNT_W  (CntW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .disp_val (disp_val),
    .byte_cnt (byte_cnt),
    .new_byte (new_byte)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  byte unsigned fifo[$];
  byte unsigned exp_rx[$];
  byte unsigned exp_tx[$];
  byte unsigned last_bytes[$];
  int model_cnt = 0;
  int rd_cnt = 0, wr_cnt = 0, nb_cnt = 0, cyc = 0, last_pop = 0;
  bit have_last = 0, stream_chk = 0, prev_rd = 0, prev_wr = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected display: the last NBytes received bytes, oldest in the top byte.
  function automatic logic [DispW-1:0] model_disp();
    logic [DispW-1:0] d = '0;
    foreach (last_bytes[i]) d = (d << 8) | DispW'(last_bytes[i]);
    return d;
  endfunction

  // First-word fall-through FIFO model; pops when the strobe was seen high.
  always @(negedge clk) begin
    if (!reset && bus.rd_uart && fifo.size() > 0) void'(fifo.pop_front());
    bus.rx_empty = (fifo.size() == 0);
    bus.r_data   = (fifo.size() > 0) ? fifo[0] : 8'h00;
  end

  // Monitor: checks every strobe against the scoreboard queues.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (bus.rd_uart) begin
        rd_cnt++;
        check("new_byte_with_rd", 32'(new_byte), 32'd1);
        check("rd_not_back_to_back", 32'(prev_rd), 32'd0);
        if (stream_chk && have_last) check("pop_gap", cyc - last_pop, PopGap);
        last_pop  = cyc;
        have_last = 1'b1;
      end
      if (new_byte) begin
        byte unsigned b;
        nb_cnt++;
        if (exp_rx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", disp_val[7:0]);
        end else begin
          b = exp_rx.pop_front();
          last_bytes.push_back(b);
          if (last_bytes.size() > NBytes) void'(last_bytes.pop_front());
          model_cnt = (model_cnt + 1) % (1 << CntW);
          check("disp_val", 32'(disp_val), 32'(model_disp()));
          check("byte_cnt", 32'(byte_cnt), model_cnt);
`ifdef UART_RX_ECHO_EN
          exp_tx.push_back(b);
`endif
        end
      end
      if (bus.wr_uart) begin
        wr_cnt++;
        check("wr_not_back_to_back", 32'(prev_wr), 32'd0);
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_echo: got %0h expected none", bus.w_data);
        end else begin
          check("echo_data", 32'(bus.w_data), 32'(exp_tx.pop_front()));
        end
      end
      prev_rd = bus.rd_uart;
      prev_wr = bus.wr_uart;
    end else begin
      prev_rd = 1'b0;
      prev_wr = 1'b0;
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push(byte unsigned b);
    fifo.push_back(b);
    exp_rx.push_back(b);
  endtask

  task automatic wait_drained(string name, int max_cyc);
    int n = 0;
    while ((fifo.size() != 0 || exp_rx.size() != 0) && n < max_cyc) begin
      tick(1);
      n++;
    end
    checks++;
    if (fifo.size() != 0 || exp_rx.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d bytes left expected 0", name, fifo.size() + exp_rx.size());
    end
    tick(5);
  endtask

  task automatic wait_pop(string name, int max_cyc);
    int r0 = rd_cnt;
    int n  = 0;
    while (rd_cnt == r0 && n < max_cyc) begin
      tick(1);
      n++;
    end
    check(name, rd_cnt, r0 + 1);
  endtask

  task automatic flush_model();
    fifo.delete();
    exp_rx.delete();
    exp_tx.delete();
    last_bytes.delete();
    model_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, w0, n0;
    bus.tx_full = 1'b0;

    // Reset with a byte already waiting.
    tick(2);
    push(8'h3A);
    tick(2);
    check("rst_disp_val", 32'(disp_val), 32'd0);
    check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
    check("rst_new_byte", 32'(new_byte), 32'd0);
    check("rst_rd_uart", 32'(bus.rd_uart), 32'd0);
    check("rst_wr_uart", 32'(bus.wr_uart), 32'd0);
    check("rst_w_data", 32'(bus.w_data), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("no_rd_after_edge1", 32'(bus.rd_uart), 32'd0);

    push(8'hC5);
    wait_drained("t2_drain", 50);
    check("t2_disp_val", 32'(disp_val), 32'h3AC5);
    check("t2_byte_cnt", 32'(byte_cnt), 32'd2);
    check("t2_rd_pulses", rd_cnt, 2);
    check("t2_nb_pulses", nb_cnt, 2);

`ifdef UART_RX_ECHO_EN
    // TX backpressure holds both echo and further pops.
    bus.tx_full = 1'b1;
    push(8'h7E);
    push(8'h11);
    wait_pop("t3_first_pop", 20);
    r0 = rd_cnt;
    w0 = wr_cnt;
    tick(10);
    check("t3_no_pop_in_hold", rd_cnt, r0);
    check("t3_no_echo_in_hold", wr_cnt, w0);
    bus.tx_full = 1'b0;
    tick(2);
    check("t3_one_echo", wr_cnt, w0 + 1);
    wait_drained("t3_drain", 50);
    check("t3_total_echo", wr_cnt, w0 + 2);
    bus.tx_full = 1'b1;
`endif

    // Reset while the byte is in flight (ECHO or WAIT).
    push(8'hAA);
    wait_pop("t5_pop", 20);
    w0 = wr_cnt;
    reset = 1'b1;
    flush_model();
    tick(2);
    check("t5_disp_in_reset", 32'(disp_val), 32'd0);
    check("t5_cnt_in_reset", 32'(byte_cnt), 32'd0);
    reset = 1'b0;
    bus.tx_full = 1'b0;
    tick(10);
    check("t5_echo_dropped", wr_cnt, w0);
    check("t5_disp_cleared", 32'(disp_val), 32'd0);

    // Long stream with the FIFO never empty.
    r0 = rd_cnt;
    n0 = nb_cnt;
    have_last  = 1'b0;
    stream_chk = 1'b1;
    for (int i = 0; i < 300; i++) push(8'($urandom_range(0, 255)));
    wait_drained("t4_drain", 300 * PopGap + 50);
    stream_chk = 1'b0;
    check("t4_byte_cnt", 32'(byte_cnt), 32'd44);
    check("t4_rd_pulses", rd_cnt - r0, 300);
    check("t4_nb_pulses", nb_cnt - n0, 300);

    // Short random bursts with random TX backpressure.
    for (int k = 0; k < 20; k++) begin
      push(8'($urandom_range(0, 255)));
      bus.tx_full = 1'($urandom_range(0, 1));
      tick($urandom_range(1, 4));
      bus.tx_full = 1'b0;
    end
    wait_drained("rand_drain", 200);

`ifdef UART_RX_ECHO_EN
    check("echo_all_sent", exp_tx.size(), 0);
`else
    check("echo_off_wr_count", wr_cnt, 0);
    check("echo_off_w_data", 32'(bus.w_data), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
